// File: rtl/bus_term_port_if.sv
// Host/bus signal bundle for one bus terminal port.
// The slave modport is the port itself; the master modport is the host and bus side.
interface bus_term_port_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
);
  localparam int cw = $clog2(depth + 1);

  logic               tx_wr;
  logic [pckg_sz-1:0] tx_data;
  logic               tx_full;
  logic [cw-1:0]      tx_count;
  logic               tx_ovf;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_vld;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_rd;
  logic [7:0]         rx_ovf_cnt;
  logic [7:0]         rx_mis_cnt;

  modport slave (
    input  tx_wr, tx_data, pop, push, D_push, rx_rd,
    output tx_full, tx_count, tx_ovf, pndng, D_pop,
           rx_vld, rx_data, rx_ovf_cnt, rx_mis_cnt
  );

  modport master (
    output tx_wr, tx_data, pop, push, D_push, rx_rd,
    input  tx_full, tx_count, tx_ovf, pndng, D_pop,
           rx_vld, rx_data, rx_ovf_cnt, rx_mis_cnt
  );
endinterface

// File: rtl/bus_term_port.sv
// Bus terminal port: TX FIFO from host to bus, and an address-filtered RX FIFO from bus to host.
// Full/empty come from occupancy counts; heads are first-word fall-through and read 0 when empty.
module bus_term_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  bus_term_port_if.slave  bus
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  logic [pckg_sz-1:0] tx_mem_r [depth];
  logic [aw-1:0]      tx_wr_ptr_r;
  logic [aw-1:0]      tx_rd_ptr_r;
  logic [cw-1:0]      tx_cnt_r;
  logic               tx_ovf_r;

  logic [pckg_sz-1:0] rx_mem_r [depth];
  logic [aw-1:0]      rx_wr_ptr_r;
  logic [aw-1:0]      rx_rd_ptr_r;
  logic [cw-1:0]      rx_cnt_r;
  logic [7:0]         rx_ovf_cnt_r;
  logic [7:0]         rx_mis_cnt_r;

  logic               tx_full_s, tx_nempty_s, tx_wr_ok_s, tx_pop_ok_s;
  logic               rx_full_s, rx_nempty_s, rx_hit_s, rx_wr_ok_s, rx_rd_ok_s;
  logic [7:0]         rx_dest_s;
  logic [pckg_sz-1:0] tx_head_s, rx_head_s;

  // Flag decode and handshake qualification, all from registered occupancy
  always_comb begin
    tx_full_s   = (tx_cnt_r == cw'(depth));
    tx_nempty_s = (tx_cnt_r != {cw{1'b0}});
    rx_full_s   = (rx_cnt_r == cw'(depth));
    rx_nempty_s = (rx_cnt_r != {cw{1'b0}});
    tx_wr_ok_s  = bus.tx_wr && !tx_full_s;
    tx_pop_ok_s = bus.pop && tx_nempty_s;
    rx_dest_s   = bus.D_push[pckg_sz-1 -: 8];
    rx_hit_s    = (rx_dest_s == id) || (rx_dest_s == broadcast);
    rx_wr_ok_s  = bus.push && rx_hit_s && !rx_full_s;
    rx_rd_ok_s  = bus.rx_rd && rx_nempty_s;
    if (tx_nempty_s) begin
      tx_head_s = tx_mem_r[tx_rd_ptr_r];
    end else begin
      tx_head_s = {pckg_sz{1'b0}};
    end
    if (rx_nempty_s) begin
      rx_head_s = rx_mem_r[rx_rd_ptr_r];
    end else begin
      rx_head_s = {pckg_sz{1'b0}};
    end
  end

  // TX FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) tx_mem_r[i] <= {pckg_sz{1'b0}};
      tx_wr_ptr_r <= {aw{1'b0}};
      tx_rd_ptr_r <= {aw{1'b0}};
      tx_cnt_r    <= {cw{1'b0}};
      tx_ovf_r    <= 1'b0;
    end else begin
      if (tx_wr_ok_s) begin
        tx_mem_r[tx_wr_ptr_r] <= bus.tx_data;
        tx_wr_ptr_r           <= tx_wr_ptr_r + aw'(1);
      end
      if (tx_pop_ok_s) begin
        tx_rd_ptr_r <= tx_rd_ptr_r + aw'(1);
      end
      case ({tx_wr_ok_s, tx_pop_ok_s})
        2'b10:   tx_cnt_r <= tx_cnt_r + cw'(1);
        2'b01:   tx_cnt_r <= tx_cnt_r - cw'(1);
        default: tx_cnt_r <= tx_cnt_r;
      endcase
      if (bus.tx_wr && tx_full_s) begin
        tx_ovf_r <= 1'b1;
      end
    end
  end

  // RX FIFO storage, pointers, occupancy and saturating drop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) rx_mem_r[i] <= {pckg_sz{1'b0}};
      rx_wr_ptr_r  <= {aw{1'b0}};
      rx_rd_ptr_r  <= {aw{1'b0}};
      rx_cnt_r     <= {cw{1'b0}};
      rx_ovf_cnt_r <= 8'd0;
      rx_mis_cnt_r <= 8'd0;
    end else begin
      if (rx_wr_ok_s) begin
        rx_mem_r[rx_wr_ptr_r] <= bus.D_push;
        rx_wr_ptr_r           <= rx_wr_ptr_r + aw'(1);
      end
      if (rx_rd_ok_s) begin
        rx_rd_ptr_r <= rx_rd_ptr_r + aw'(1);
      end
      case ({rx_wr_ok_s, rx_rd_ok_s})
        2'b10:   rx_cnt_r <= rx_cnt_r + cw'(1);
        2'b01:   rx_cnt_r <= rx_cnt_r - cw'(1);
        default: rx_cnt_r <= rx_cnt_r;
      endcase
      if (bus.push && rx_hit_s && rx_full_s && (rx_ovf_cnt_r != 8'hFF)) begin
        rx_ovf_cnt_r <= rx_ovf_cnt_r + 8'd1;
      end
      if (bus.push && !rx_hit_s && (rx_mis_cnt_r != 8'hFF)) begin
        rx_mis_cnt_r <= rx_mis_cnt_r + 8'd1;
      end
    end
  end

  assign bus.tx_full    = tx_full_s;
  assign bus.tx_count   = tx_cnt_r;
  assign bus.tx_ovf     = tx_ovf_r;
  assign bus.pndng      = tx_nempty_s;
  assign bus.D_pop      = tx_head_s;
  assign bus.rx_vld     = rx_nempty_s;
  assign bus.rx_data    = rx_head_s;
  assign bus.rx_ovf_cnt = rx_ovf_cnt_r;
  assign bus.rx_mis_cnt = rx_mis_cnt_r;
endmodule

// File: tb/tb_bus_term_port.sv
// Directed bench for bus_term_port (pckg_sz=16, depth=4, id=8'h02) with hand-computed expectations.
module tb_bus_term_port;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  bus_term_port_if #(.pckg_sz(16), .depth(4)) bus ();

  bus_term_port #(
    .pckg_sz(16), .depth(4), .id(8'h02), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pndng"},   32'(bus.pndng),      32'h0);
    chk({tag, " tx_full"}, 32'(bus.tx_full),    32'h0);
    chk({tag, " tx_cnt"},  32'(bus.tx_count),   32'h0);
    chk({tag, " tx_ovf"},  32'(bus.tx_ovf),     32'h0);
    chk({tag, " D_pop"},   32'(bus.D_pop),      32'h0);
    chk({tag, " rx_vld"},  32'(bus.rx_vld),     32'h0);
    chk({tag, " rx_data"}, 32'(bus.rx_data),    32'h0);
    chk({tag, " rx_ovf"},  32'(bus.rx_ovf_cnt), 32'h0);
    chk({tag, " rx_mis"},  32'(bus.rx_mis_cnt), 32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.tx_wr = 1'b0; bus.tx_data = 16'h0; bus.pop = 1'b0;
    bus.push = 1'b0; bus.D_push = 16'h0; bus.rx_rd = 1'b0;

    // Reset, then idle
    #3;
    chk_all_zero("rst");
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk_all_zero("idle");

    // TX basic write/pop ordering
    bus.tx_wr = 1'b1; bus.tx_data = 16'h02AA; tick();
    chk("tx1 pndng", 32'(bus.pndng), 32'h1);
    chk("tx1 D_pop", 32'(bus.D_pop), 32'h02AA);
    chk("tx1 cnt", 32'(bus.tx_count), 32'h1);
    bus.tx_data = 16'h0355; tick();
    chk("tx2 D_pop", 32'(bus.D_pop), 32'h02AA);
    chk("tx2 cnt", 32'(bus.tx_count), 32'h2);
    bus.tx_wr = 1'b0; bus.pop = 1'b1; tick();
    chk("tx3 pndng", 32'(bus.pndng), 32'h1);
    chk("tx3 D_pop", 32'(bus.D_pop), 32'h0355);
    chk("tx3 cnt", 32'(bus.tx_count), 32'h1);
    tick();
    chk("tx4 pndng", 32'(bus.pndng), 32'h0);
    chk("tx4 cnt", 32'(bus.tx_count), 32'h0);
    chk("tx4 D_pop", 32'(bus.D_pop), 32'h0);
    tick();
    chk("tx pop empty cnt", 32'(bus.tx_count), 32'h0);
    bus.pop = 1'b0;

    // TX fill, overflow, write+pop while full
    for (int i = 0; i < 5; i++) begin
      bus.tx_wr = 1'b1; bus.tx_data = 16'h0100 + 16'(i); tick();
      if (i == 3) begin
        chk("full after 4", 32'(bus.tx_full), 32'h1);
        chk("ovf before 5th", 32'(bus.tx_ovf), 32'h0);
      end
    end
    chk("cnt after 5", 32'(bus.tx_count), 32'h4);
    chk("ovf after 5", 32'(bus.tx_ovf), 32'h1);
    bus.tx_data = 16'h0999; bus.pop = 1'b1; tick();
    chk("wrpop full cnt", 32'(bus.tx_count), 32'h3);
    chk("wrpop full flag", 32'(bus.tx_full), 32'h0);
    chk("wrpop full head", 32'(bus.D_pop), 32'h0101);
    bus.tx_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain head", 32'(bus.D_pop), (i < 2) ? 32'h0102 + 32'(i) : 32'h0);
    end
    bus.pop = 1'b0;
    chk("drain cnt", 32'(bus.tx_count), 32'h0);
    chk("ovf sticky", 32'(bus.tx_ovf), 32'h1);

    // RX filter: own id, broadcast, mismatch
    bus.push = 1'b1; bus.D_push = 16'h0211; tick();
    chk("rx1 vld", 32'(bus.rx_vld), 32'h1);
    chk("rx1 data", 32'(bus.rx_data), 32'h0211);
    bus.D_push = 16'hFF22; tick();
    chk("rx2 data", 32'(bus.rx_data), 32'h0211);
    bus.D_push = 16'h0533; tick();
    chk("rx mis", 32'(bus.rx_mis_cnt), 32'h1);
    bus.push = 1'b0; bus.rx_rd = 1'b1; tick();
    chk("rx rd1 data", 32'(bus.rx_data), 32'hFF22);
    tick();
    chk("rx rd2 vld", 32'(bus.rx_vld), 32'h0);
    chk("rx rd2 data", 32'(bus.rx_data), 32'h0);
    bus.rx_rd = 1'b0;

    // RX overflow and over-read
    for (int i = 0; i < 5; i++) begin
      bus.push = 1'b1; bus.D_push = 16'h0200 + 16'(i); tick();
    end
    bus.push = 1'b0;
    chk("rx ovf cnt", 32'(bus.rx_ovf_cnt), 32'h1);
    chk("rx full head", 32'(bus.rx_data), 32'h0200);
    bus.rx_rd = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rx over-read vld", 32'(bus.rx_vld), (j < 3) ? 32'h1 : 32'h0);
      chk("rx over-read data", 32'(bus.rx_data), (j < 3) ? 32'h0201 + 32'(j) : 32'h0);
    end
    bus.rx_rd = 1'b0;
    chk("rx mis kept", 32'(bus.rx_mis_cnt), 32'h1);

    // TX pointer wrap, then asynchronous reset while pending
    for (int i = 0; i < 3; i++) begin
      bus.tx_wr = 1'b1; bus.tx_data = 16'h0300 + 16'(i); tick();
    end
    for (int i = 0; i < 10; i++) begin
      bus.tx_wr = 1'b1; bus.pop = 1'b1; bus.tx_data = 16'h0303 + 16'(i); tick();
      chk("wrap cnt", 32'(bus.tx_count), 32'h3);
      chk("wrap head", 32'(bus.D_pop), 32'h0301 + 32'(i));
    end
    bus.tx_wr = 1'b0; bus.pop = 1'b0;
    chk("pre-reset pndng", 32'(bus.pndng), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async rst");
    reset = 1'b1;
    bus.tx_wr = 1'b1; bus.tx_data = 16'h0777; tick();
    bus.tx_wr = 1'b0;
    chk("post-rst D_pop", 32'(bus.D_pop), 32'h0777);
    chk("post-rst pndng", 32'(bus.pndng), 32'h1);
    chk("post-rst cnt", 32'(bus.tx_count), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
